display_scan_ctrl: RTL

Time-multiplexed scan controller for a bank of common-segment seven-segment digits. It shares one hex-to-segment decoder among NDIGITS digits. It walks a one-hot digit enable at a fixed refresh rate, with a blanking guard at every digit change. New display values are double-buffered so a frame never shows a mix of old and new digits. It sits between the register/value source and the board's segment and digit-enable pins.

---
 rtl/display_scan_ctrl_pkg.sv | 32 +++
 rtl/display_scan_ctrl_hex_to_seg.sv | 32 +++
 rtl/display_scan_ctrl.sv | 116 +++++++++++
 3 files changed

// File: rtl/display_scan_ctrl_pkg.sv
// Shared segment constants for the seven-segment scan controller.
// Bit positions follow seg[6]=a down to seg[0]=g.
package display_scan_ctrl_pkg;

  localparam int unsigned SEG_A = 6;
  localparam int unsigned SEG_B = 5;
  localparam int unsigned SEG_C = 4;
  localparam int unsigned SEG_D = 3;
  localparam int unsigned SEG_E = 2;
  localparam int unsigned SEG_F = 1;
  localparam int unsigned SEG_G = 0;

  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam logic [6:0] SEG_HEX_0 = 7'h7E;
  localparam logic [6:0] SEG_HEX_1 = 7'h30;
  localparam logic [6:0] SEG_HEX_2 = 7'h6D;
  localparam logic [6:0] SEG_HEX_3 = 7'h79;
  localparam logic [6:0] SEG_HEX_4 = 7'h33;
  localparam logic [6:0] SEG_HEX_5 = 7'h5B;
  localparam logic [6:0] SEG_HEX_6 = 7'h5F;
  localparam logic [6:0] SEG_HEX_7 = 7'h70;
  localparam logic [6:0] SEG_HEX_8 = 7'h7F;
  localparam logic [6:0] SEG_HEX_9 = 7'h7B;
  localparam logic [6:0] SEG_HEX_A = 7'h77;
  localparam logic [6:0] SEG_HEX_B = 7'h1F;
  localparam logic [6:0] SEG_HEX_C = 7'h4E;
  localparam logic [6:0] SEG_HEX_D = 7'h3D;
  localparam logic [6:0] SEG_HEX_E = 7'h4F;
  localparam logic [6:0] SEG_HEX_F = 7'h47;

endpackage

// File: rtl/display_scan_ctrl_hex_to_seg.sv
// Combinational hex nibble to active-high seven-segment pattern.
module hex_to_seg
  import display_scan_ctrl_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (nibble)
      4'h0: seg = SEG_HEX_0;
      4'h1: seg = SEG_HEX_1;
      4'h2: seg = SEG_HEX_2;
      4'h3: seg = SEG_HEX_3;
      4'h4: seg = SEG_HEX_4;
      4'h5: seg = SEG_HEX_5;
      4'h6: seg = SEG_HEX_6;
      4'h7: seg = SEG_HEX_7;
      4'h8: seg = SEG_HEX_8;
      4'h9: seg = SEG_HEX_9;
      4'hA: seg = SEG_HEX_A;
      4'hB: seg = SEG_HEX_B;
      4'hC: seg = SEG_HEX_C;
      4'hD: seg = SEG_HEX_D;
      4'hE: seg = SEG_HEX_E;
      4'hF: seg = SEG_HEX_F;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/display_scan_ctrl.sv
// Multiplexed seven-segment scan controller with blanking guard, leading-zero
// suppression and a frame-aligned double buffer for the displayed value.
module display_scan_ctrl
  import display_scan_ctrl_pkg::*;
#(
  parameter int unsigned NDIGITS      = 4,
  parameter int unsigned DIV          = 1000,
  parameter int unsigned BLANK_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [4*NDIGITS-1:0] value,
  input  logic                 lz_en,
  output logic [6:0]           seg,
  output logic [NDIGITS-1:0]   an,
  output logic                 frame_done
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned IW = $clog2(NDIGITS);
  localparam int unsigned VW = 4 * NDIGITS;

  localparam logic [CW-1:0] CntMax   = CW'(DIV - 1);
  localparam logic [CW-1:0] CntBlank = CW'(BLANK_CYCLES);
  localparam logic [IW-1:0] IdxMax   = IW'(NDIGITS - 1);

  // cnt_q/idx_q name the slot position the output registers load at the next edge.
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [VW-1:0]      act_q, pend_q;
  logic               pf_q, pf_d;
  logic               wrap_q;
  logic [6:0]         seg_q;
  logic [NDIGITS-1:0] an_q, an_d;
  logic               fd_q;

  logic               slot_end, frame_end;
  logic [3:0]         nibble;
  logic               upper_zero, suppress;
  logic [6:0]         dec_seg;

  hex_to_seg u_hex_to_seg (
    .nibble (nibble),
    .seg    (dec_seg)
  );

  always_comb begin
    slot_end  = (cnt_q == CntMax);
    frame_end = slot_end && (idx_q == IdxMax);
    cnt_d     = slot_end ? '0 : cnt_q + 1'b1;
    idx_d     = idx_q;
    if (slot_end) begin
      idx_d = (idx_q == IdxMax) ? '0 : idx_q + 1'b1;
    end
    // A load on the boundary edge re-arms the flag for the following frame.
    pf_d = load | (pf_q & ~frame_end);
  end

  always_comb begin
    nibble     = 4'h0;
    upper_zero = 1'b1;
    for (int i = 0; i < NDIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        nibble = act_q[4*i +: 4];
      end
      if ((IW'(i) >= idx_q) && (act_q[4*i +: 4] != 4'h0)) begin
        upper_zero = 1'b0;
      end
    end
    suppress = lz_en && (idx_q != '0) && upper_zero;
  end

  always_comb begin
    an_d = '0;
    for (int i = 0; i < NDIGITS; i++) begin
      an_d[i] = (cnt_q >= CntBlank) && (idx_q == IW'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      idx_q  <= '0;
      act_q  <= '0;
      pend_q <= '0;
      pf_q   <= 1'b0;
      wrap_q <= 1'b0;
      seg_q  <= SEG_BLANK;
      an_q   <= '0;
      fd_q   <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      pf_q   <= pf_d;
      wrap_q <= frame_end;
      an_q   <= an_d;
      fd_q   <= wrap_q;
      if (load) begin
        pend_q <= value;
      end
      if (frame_end && pf_q) begin
        act_q <= pend_q;
      end
      // Segments only update on the first (blanked) cycle of a slot.
      if (cnt_q == '0) begin
        seg_q <= suppress ? SEG_BLANK : dec_seg;
      end
    end
  end

  assign seg        = seg_q;
  assign an         = an_q;
  assign frame_done = fd_q;

endmodule
